// File: rtl/counter_scoreboard.sv
// ---------------------------------------------------------------------------
// counter_scoreboard
//
// Purpose
//   Cycle-accurate checker for the counter DUT. It sits beside the counter-env
//   monitor and samples the same stimulus the DUT sees (enable/load/data) along
//   with the DUT response (count/even). It runs its own reference counter,
//   compares every cycle once armed, and reports mismatches, error and compare
//   totals, and an overall pass/fail status.
//
// Parameters
//   WIDTH     counter/data width in bits
//   MAX_ERRS  error count at which the block latches FAILED
//   CHK_W     width of the checked-cycle counter
//
// Ports
//   clk_i        in   sampling clock, shared with the DUT
//   rst_n_i      in   asynchronous active-low reset, shared with the DUT
//   enable_i     in   DUT enable (sampled)
//   load_i       in   DUT load (sampled)
//   data_i       in   DUT load data (sampled)
//   count_i      in   DUT count output
//   even_i       in   DUT even output
//   exp_count_o  out  reference-model count
//   mismatch_o   out  one-cycle pulse: the previous cycle's compare failed
//   err_cnt_o    out  mismatches seen, saturating at MAX_ERRS
//   chk_cnt_o    out  compares performed, saturating at all-ones
//   state_o      out  2'b00 ARM, 2'b01 CHECK, 2'b10 FAILED
//   pass_o       out  high while in CHECK with no errors recorded
//
// Optional feature (macro COUNTER_SB_CAPTURE_EN)
//   Adds first_exp_o, first_act_o, first_cyc_o and first_vld_o. The first
//   mismatch after reset latches the expected count, the observed count and
//   the compare index (chk_cnt_o before it advances); later mismatches leave
//   the capture untouched until the next reset.
// ---------------------------------------------------------------------------
module counter_scoreboard #(
    parameter int WIDTH    = 4,
    parameter int MAX_ERRS = 15,
    parameter int CHK_W    = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              enable_i,
    input  logic                              load_i,
    input  logic [WIDTH-1:0]                  data_i,
    input  logic [WIDTH-1:0]                  count_i,
    input  logic                              even_i,
    output logic [WIDTH-1:0]                  exp_count_o,
    output logic                              mismatch_o,
    output logic [$clog2(MAX_ERRS+1)-1:0]     err_cnt_o,
    output logic [CHK_W-1:0]                  chk_cnt_o,
    output logic [1:0]                        state_o,
    output logic                              pass_o
`ifdef COUNTER_SB_CAPTURE_EN
   ,output logic [WIDTH-1:0]                  first_exp_o,
    output logic [WIDTH-1:0]                  first_act_o,
    output logic [CHK_W-1:0]                  first_cyc_o,
    output logic                              first_vld_o
`endif
);

    localparam int               EW      = $clog2(MAX_ERRS + 1);
    localparam logic [EW-1:0]    ERR_MAX = EW'(MAX_ERRS);
    localparam logic [CHK_W-1:0] CHK_MAX = '1;

    typedef enum logic [1:0] {
        ST_ARM    = 2'b00,
        ST_CHECK  = 2'b01,
        ST_FAILED = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] exp_q,   exp_d;
    logic             mismatch_q, mismatch_d;
    logic [EW-1:0]    err_q,   err_d;
    logic [CHK_W-1:0] chk_q,   chk_d;

    logic             compare_en;
    logic             miss;

    // -----------------------------------------------------------------------
    // Reference counter. It runs in every state, including ARM, so that it
    // tracks the DUT from the very first edge after reset release.
    // -----------------------------------------------------------------------
    always_comb begin
        exp_d = exp_q;
        if (load_i) begin
            exp_d = data_i;                    // load beats enable
        end else if (enable_i) begin
            exp_d = exp_q + WIDTH'(1);         // natural wrap at 2^WIDTH
        end
    end

    // Case inequality so that an X/Z on the DUT outputs is a mismatch rather
    // than silently matching.
    always_comb begin
        miss = (count_i !== exp_q) || (even_i !== ~exp_q[0]);
    end

    // -----------------------------------------------------------------------
    // Compare bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        mismatch_d = compare_en & miss;

        chk_d = chk_q;
        if (compare_en && (chk_q != CHK_MAX)) begin
            chk_d = chk_q + CHK_W'(1);
        end

        err_d = err_q;
        if (compare_en && miss && (err_q != ERR_MAX)) begin
            err_d = err_q + EW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
            chk_q      <= '0;
        end else begin
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            chk_q      <= chk_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. FAILED is entered on the same edge that the error
    // counter lands on MAX_ERRS, so the two are never seen out of step.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ARM:    state_d = ST_CHECK;
            ST_CHECK:  if (err_d == ERR_MAX) state_d = ST_FAILED;
            ST_FAILED: state_d = ST_FAILED;
            default:   state_d = ST_ARM;
        endcase
    end

    // FSM: outputs. ARM is a one-cycle settle state with no compare; both the
    // DUT and the model hold 0 across it.
    always_comb begin
        compare_en = 1'b0;
        pass_o     = 1'b0;
        unique case (state_q)
            ST_ARM:    compare_en = 1'b0;
            ST_CHECK: begin
                compare_en = 1'b1;
                pass_o     = (err_q == '0);
            end
            ST_FAILED: compare_en = 1'b1;
            default:   compare_en = 1'b0;
        endcase
    end

    assign exp_count_o = exp_q;
    assign mismatch_o  = mismatch_q;
    assign err_cnt_o   = err_q;
    assign chk_cnt_o   = chk_q;
    assign state_o     = state_q;

`ifdef COUNTER_SB_CAPTURE_EN
    // -----------------------------------------------------------------------
    // First-mismatch capture
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] first_exp_q, first_exp_d;
    logic [WIDTH-1:0] first_act_q, first_act_d;
    logic [CHK_W-1:0] first_cyc_q, first_cyc_d;
    logic             first_vld_q, first_vld_d;

    always_comb begin
        first_exp_d = first_exp_q;
        first_act_d = first_act_q;
        first_cyc_d = first_cyc_q;
        first_vld_d = first_vld_q;
        if (compare_en && miss && !first_vld_q) begin
            first_exp_d = exp_q;
            first_act_d = count_i;
            first_cyc_d = chk_q;               // index of the failing compare
            first_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            first_exp_q <= '0;
            first_act_q <= '0;
            first_cyc_q <= '0;
            first_vld_q <= 1'b0;
        end else begin
            first_exp_q <= first_exp_d;
            first_act_q <= first_act_d;
            first_cyc_q <= first_cyc_d;
            first_vld_q <= first_vld_d;
        end
    end

    assign first_exp_o = first_exp_q;
    assign first_act_o = first_act_q;
    assign first_cyc_o = first_cyc_q;
    assign first_vld_o = first_vld_q;
`endif

endmodule

// File: tb/tb_counter_scoreboard.sv
// Directed bench for counter_scoreboard. The bench plays the part of a
// correct counter DUT (optionally corrupting its outputs) and keeps an
// integer-level model of what the scoreboard must report.
module tb_counter_scoreboard;
    localparam int WIDTH    = 4;
    localparam int MAX_ERRS = 15;
    localparam int CHK_W    = 16;
    localparam int EW       = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             enable, load, even;
    logic [WIDTH-1:0] data, count;

    logic [WIDTH-1:0] exp_count_o;
    logic             mismatch_o, pass_o;
    logic [EW-1:0]    err_cnt_o;
    logic [CHK_W-1:0] chk_cnt_o;
    logic [1:0]       state_o;
`ifdef COUNTER_SB_CAPTURE_EN
    logic [WIDTH-1:0] first_exp_o, first_act_o;
    logic [CHK_W-1:0] first_cyc_o;
    logic             first_vld_o;
`endif

    counter_scoreboard #(.WIDTH(WIDTH), .MAX_ERRS(MAX_ERRS), .CHK_W(CHK_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .load_i(load),
        .data_i(data), .count_i(count), .even_i(even),
        .exp_count_o(exp_count_o), .mismatch_o(mismatch_o), .err_cnt_o(err_cnt_o),
        .chk_cnt_o(chk_cnt_o), .state_o(state_o), .pass_o(pass_o)
`ifdef COUNTER_SB_CAPTURE_EN
       ,.first_exp_o(first_exp_o), .first_act_o(first_act_o),
        .first_cyc_o(first_cyc_o), .first_vld_o(first_vld_o)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit run_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model (integers, spec rules) ----------------
    // state: 0 ARM, 1 CHECK, 2 FAILED
    int m_exp, m_mis, m_err, m_chk, m_state;
    int m_fexp, m_fact, m_fcyc, m_fvld;
    bit m_miss;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_exp = 0; m_mis = 0; m_err = 0; m_chk = 0; m_state = 0;
            m_fexp = 0; m_fact = 0; m_fcyc = 0; m_fvld = 0;
        end else begin
            if (m_state == 0) begin
                m_mis   = 0;
                m_state = 1;
            end else begin
                m_miss = (int'(count) != m_exp) || (even != ((m_exp % 2) == 0));
                if (m_miss && m_fvld == 0) begin
                    m_fvld = 1; m_fexp = m_exp; m_fact = int'(count); m_fcyc = m_chk;
                end
                m_mis = m_miss ? 1 : 0;
                if (m_chk < 65535) m_chk = m_chk + 1;
                if (m_miss && m_err < MAX_ERRS) m_err = m_err + 1;
                if (m_state == 1 && m_err == MAX_ERRS) m_state = 2;
            end
            if (load)        m_exp = int'(data);
            else if (enable) m_exp = (m_exp + 1) % 16;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run_chk) begin
            chk("exp_count", exp_count_o, m_exp);
            chk("mismatch",  mismatch_o,  m_mis);
            chk("err_cnt",   err_cnt_o,   m_err);
            chk("chk_cnt",   chk_cnt_o,   m_chk);
            chk("state",     state_o,     m_state);
            chk("pass",      pass_o,      (m_state == 1 && m_err == 0) ? 1 : 0);
`ifdef COUNTER_SB_CAPTURE_EN
            chk("first_vld", first_vld_o, m_fvld);
            chk("first_exp", first_exp_o, m_fexp);
            chk("first_act", first_act_o, m_fact);
            chk("first_cyc", first_cyc_o, m_fcyc);
`endif
        end
    end

    // One cycle: drive at negedge as a correct counter (optionally corrupted),
    // then advance to the next negedge.
    task automatic cyc(input logic en, input logic ld, input logic [3:0] d,
                       input logic [3:0] cmask, input logic eflip);
        enable = en; load = ld; data = d;
        count  = 4'(m_exp) ^ cmask;
        even   = ((m_exp % 2) == 0) ^ eflip;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; enable = 0; load = 0; data = 0; count = 0; even = 1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        run_chk = 1;
        @(negedge clk);
        chk("rst_state", state_o, 0);
        chk("rst_pass", pass_o, 0);
        chk("rst_exp", exp_count_o, 0);
        rst_n = 1'b1;

        // counting with wrap
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (i == 15) chk("wrap_to_0", exp_count_o, 0);
        end
        chk("cnt20_exp", exp_count_o, 4);
        chk("cnt20_chk", chk_cnt_o, 19);
        chk("cnt20_err", err_cnt_o, 0);
        chk("cnt20_pass", pass_o, 1);

        // load beats enable
        cyc(1, 1, 9, 0, 0);
        chk("load_wins", exp_count_o, 9);
        cyc(0, 0, 0, 0, 0);
        chk("odd_ok", mismatch_o, 0);

        // even-only corruption at exp=4
        cyc(0, 1, 4, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("even_mis", mismatch_o, 1);
        chk("even_err", err_cnt_o, 1);
        chk("even_pass", pass_o, 0);
        cyc(0, 0, 0, 0, 0);
        chk("even_pulse1", mismatch_o, 0);

        // count 5 while exp=6
        cyc(0, 1, 6, 0, 0);
        cyc(0, 0, 0, 4'h3, 0);
        chk("cnt_mis", mismatch_o, 1);
        chk("cnt_err", err_cnt_o, 2);
        cyc(0, 0, 0, 0, 0);
        chk("cnt_pulse1", mismatch_o, 0);

        // saturation into FAILED
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 4'h1, 0);
        chk("sat_err", err_cnt_o, 15);
        chk("sat_state", state_o, 2);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
        chk("sticky_state", state_o, 2);
        chk("sticky_err", err_cnt_o, 15);
        chk("sticky_mis", mismatch_o, 0);
        chk("sticky_pass", pass_o, 0);
`ifdef COUNTER_SB_CAPTURE_EN
        chk("cap_vld", first_vld_o, 1);
        chk("cap_exp", first_exp_o, 4);
        chk("cap_act", first_act_o, 4);
        chk("cap_cyc", first_cyc_o, 22);
`endif

        // asynchronous reset mid-count
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
        chk("pre_rst_exp", exp_count_o, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_exp", exp_count_o, 0);
        chk("arst_err", err_cnt_o, 0);
        chk("arst_chk", chk_cnt_o, 0);
        chk("arst_state", state_o, 0);
        chk("arst_mis", mismatch_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0);
        chk("rearm_state", state_o, 1);
        chk("rearm_chk", chk_cnt_o, 0);
        chk("rearm_exp", exp_count_o, 1);
        cyc(1, 0, 0, 0, 0);
        chk("rearm_chk1", chk_cnt_o, 1);
        chk("rearm_pass", pass_o, 1);

        run_chk = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
